// File: rtl/edge_pack_writer_if.sv
// Pixel stream in, queued SRAM byte-addressed word writes out, for edge_pack_writer.
// master drives pixels and the SRAM grant; slave is the packer.
interface edge_pack_writer_if #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 32
);
  logic              pixel_in;
  logic              pixel_valid;
  logic              serpentine;
  logic [ADDR_W-1:0] base_addr;
  logic              stall;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              wr_grant;
  logic              frame_done;

  modport master (
    output pixel_in, pixel_valid, serpentine, base_addr, wr_grant,
    input  stall, wr_req, wr_addr, wr_data, frame_done
  );

  modport slave (
    input  pixel_in, pixel_valid, serpentine, base_addr, wr_grant,
    output stall, wr_req, wr_addr, wr_data, frame_done
  );
endinterface

// File: rtl/edge_pack_writer.sv
// Packs 1-bpp edge pixels into raster-ordered WORD_W-bit SRAM words; a word is queued the cycle its last pixel is accepted.
// stall = queue full with no pop this cycle, or frame wrap-up (flush/status/drain/done) in progress.
module edge_pack_writer #(
  parameter int                WORD_W      = 32,
  parameter int                IMG_W       = 640,
  parameter int                IMG_H       = 480,
  parameter int                FIFO_DEPTH  = 4,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] STATUS_ADDR = 'h4
) (
  input logic                clk,
  input logic                n_rst,
  edge_pack_writer_if.slave  bus
);

  localparam int WPR    = (IMG_W + WORD_W - 1) / WORD_W;
  localparam int WB     = WORD_W / 8;
  localparam int BIT_W  = $clog2(WORD_W);
  localparam int WIDX_W = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [BIT_W-1:0]  B_MAX      = BIT_W'(WORD_W - 1);
  localparam logic [BIT_W-1:0]  B_LAST     = BIT_W'((IMG_W - 1) % WORD_W);
  localparam logic [WIDX_W-1:0] W_LAST     = WIDX_W'(WPR - 1);
  localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] ROW_BYTES  = ADDR_W'(WPR * WB);
  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(WB);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, PACK, FLUSH, STATUS, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } entry_t;

  state_t            state_q;
  logic              frame_done_q;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [WIDX_W-1:0] w_q, w_d;
  logic [BIT_W-1:0]  b_q, b_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic              serp_q, serp_d;

  entry_t            mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              full, pop, push, push_word, push_stat, accept;
  logic              serp_eff, rtl, word_end, row_end, frame_end;
  logic [ROW_W-1:0]  row_nxt;
  logic [ADDR_W-1:0] row_base, word_addr;
  logic [WORD_W-1:0] word_now;
  entry_t            push_ent;

  assign full      = (cnt_q == CNT_FULL);
  assign pop       = (cnt_q != '0) && bus.wr_grant;
  // A pop in the same cycle frees the slot, so a full queue need not stall.
  assign bus.stall = (full && !pop) || !((state_q == IDLE) || (state_q == PACK));
  assign accept    = bus.pixel_valid && !bus.stall;

  // Frame parameters come straight from the inputs on the first pixel of a frame.
  assign serp_eff  = (state_q == IDLE) ? bus.serpentine : serp_q;
  assign row_base  = (state_q == IDLE) ? bus.base_addr  : row_base_q;
  assign rtl       = serp_eff && row_q[0];
  assign row_end   = (col_q == COL_LAST);
  assign frame_end = row_end && (row_q == ROW_LAST);
  assign row_nxt   = frame_end ? '0 : row_q + ROW_W'(1);
  assign word_end  = rtl ? (b_q == '0) : ((b_q == B_MAX) || row_end);
  assign word_addr = row_base + ADDR_W'(w_q) * WORD_BYTES;

  assign push_word = accept && word_end;
  assign push_stat = (state_q == STATUS);
  assign push      = push_word || push_stat;

  always_comb begin
    word_now                = asm_q;
    word_now[B_MAX - b_q]   = bus.pixel_in;
    push_ent.addr           = push_stat ? STATUS_ADDR : word_addr;
    push_ent.data           = push_stat ? WORD_W'(1) : word_now;
  end

  always_comb begin
    asm_d      = asm_q;
    col_d      = col_q;
    row_d      = row_q;
    w_d        = w_q;
    b_d        = b_q;
    row_base_d = row_base_q;
    serp_d     = serp_q;
    if (accept) begin
      serp_d     = serp_eff;
      row_base_d = row_base;
      asm_d      = word_end ? '0 : word_now;
      if (row_end) begin
        col_d = '0;
        row_d = row_nxt;
        if (!frame_end) row_base_d = row_base + ROW_BYTES;
        if (serp_eff && row_nxt[0]) begin
          w_d = W_LAST;
          b_d = B_LAST;
        end else begin
          w_d = '0;
          b_d = '0;
        end
      end else begin
        col_d = col_q + COL_W'(1);
        if (rtl) begin
          if (b_q == '0) begin
            w_d = w_q - WIDX_W'(1);
            b_d = B_MAX;
          end else begin
            b_d = b_q - BIT_W'(1);
          end
        end else if (word_end) begin
          w_d = w_q + WIDX_W'(1);
          b_d = '0;
        end else begin
          b_d = b_q + BIT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      frame_done_q <= 1'b0;
      asm_q        <= '0;
      col_q        <= '0;
      row_q        <= '0;
      w_q          <= '0;
      b_q          <= '0;
      row_base_q   <= '0;
      serp_q       <= 1'b0;
    end else begin
      asm_q        <= asm_d;
      col_q        <= col_d;
      row_q        <= row_d;
      w_q          <= w_d;
      b_q          <= b_d;
      row_base_q   <= row_base_d;
      serp_q       <= serp_d;
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE:    if (accept) state_q <= frame_end ? FLUSH : PACK;
        PACK:    if (accept && frame_end) state_q <= FLUSH;
        FLUSH:   if (!full) state_q <= STATUS;
        STATUS:  state_q <= DRAIN;
        DRAIN: begin
          if (cnt_q == '0) begin
            state_q      <= DONE;
            frame_done_q <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_ent;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.wr_req     = (cnt_q != '0);
  assign bus.wr_addr    = mem_q[rd_ptr_q].addr;
  assign bus.wr_data    = mem_q[rd_ptr_q].data;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_edge_pack_writer.sv
// Bench for edge_pack_writer: a 32-bit/40-pixel and a 64-bit/65-pixel instance, each checked against
// a reference queue of expected SRAM writes built from the source image.
module tb_edge_pack_writer;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  edge_pack_writer_if #(.WORD_W(32), .ADDR_W(32)) if1 ();
  edge_pack_writer_if #(.WORD_W(64), .ADDR_W(32)) if2 ();

  edge_pack_writer #(.WORD_W(32), .IMG_W(40), .IMG_H(2), .FIFO_DEPTH(2), .ADDR_W(32),
                     .STATUS_ADDR(32'h4)) dut1 (.clk(clk), .n_rst(n_rst), .bus(if1));
  edge_pack_writer #(.WORD_W(64), .IMG_W(65), .IMG_H(2), .FIFO_DEPTH(2), .ADDR_W(32),
                     .STATUS_ADDR(32'h4)) dut2 (.clk(clk), .n_rst(n_rst), .bus(if2));

  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t q1[$];
  wr_t q2[$];
  int  tests = 0;
  int  fails = 0;
  int  done1 = 0;
  int  done2 = 0;
  bit  st1, st2;
  bit  rg1 = 1'b0;
  bit  img [2][65];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected writes for a 2-row frame, in the order the words complete.
  task automatic exp_frame(input int d, input int ww, input int iw, input bit serp,
                           input logic [31:0] base);
    int  wpr = (iw + ww - 1) / ww;
    wr_t e;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < wpr; i++) begin
        int w = (serp && r == 1) ? wpr - 1 - i : i;
        e.addr = base + 32'((r * wpr + w) * (ww / 8));
        e.data = '0;
        for (int j = 0; j < ww; j++) begin
          int x = w * ww + j;
          if (x < iw && img[r][x]) e.data[ww - 1 - j] = 1'b1;
        end
        if (d == 0) q1.push_back(e); else q2.push_back(e);
      end
    end
    e.addr = 32'h4;
    e.data = 64'h1;
    if (d == 0) q1.push_back(e); else q2.push_back(e);
  endtask

  task automatic check_pop(input int d, input logic [31:0] a, input logic [63:0] dat);
    wr_t e;
    int  sz = (d == 0) ? q1.size() : q2.size();
    tests++;
    assert (sz != 0) else begin
      fails++;
      $error("FAIL unexpected_write dut%0d: observed addr %h data %h expected no write", d + 1, a, dat);
    end
    if (sz != 0) begin
      e = (d == 0) ? q1.pop_front() : q2.pop_front();
      chk((d == 0) ? "wr_addr1" : "wr_addr2", {32'b0, a}, {32'b0, e.addr});
      chk((d == 0) ? "wr_data1" : "wr_data2", dat, e.data);
    end
  endtask

  // One clock: sample at negedge, then return 1 time unit after the posedge.
  task automatic tick();
    @(negedge clk);
    st1 = if1.stall;
    st2 = if2.stall;
    if (if1.wr_req && if1.wr_grant) check_pop(0, if1.wr_addr, {32'b0, if1.wr_data});
    if (if2.wr_req && if2.wr_grant) check_pop(1, if2.wr_addr, if2.wr_data);
    if (if1.frame_done) done1++;
    if (if2.frame_done) done2++;
    @(posedge clk);
    #1;
    if (rg1) if1.wr_grant = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input int d, input bit v);
    int n   = 0;
    bit acc = 1'b0;
    if (d == 0) begin if1.pixel_in = v; if1.pixel_valid = 1'b1; end
    else        begin if2.pixel_in = v; if2.pixel_valid = 1'b1; end
    while (!acc && n < 300) begin
      tick();
      acc = (d == 0) ? !st1 : !st2;
      n++;
    end
    if (!acc) chk("pixel_accept", {63'b0, acc}, 64'h1);
    if (d == 0) if1.pixel_valid = 1'b0; else if2.pixel_valid = 1'b0;
  endtask

  task automatic send_frame1(input bit serp);
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 40; k++)
        send(0, img[r][(serp && r == 1) ? 39 - k : k]);
  endtask

  task automatic wait_done(input int d, input int target);
    int n = 0;
    while (((d == 0) ? done1 : done2) < target && n < 400) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk((d == 0) ? "frame_done1_count" : "frame_done2_count",
        64'((d == 0) ? done1 : done2), 64'(target));
    chk((d == 0) ? "sb1_left" : "sb2_left", 64'((d == 0) ? q1.size() : q2.size()), 64'h0);
  endtask

  initial begin
    n_rst = 1'b0;
    if1.pixel_in = 1'b0; if1.pixel_valid = 1'b0; if1.serpentine = 1'b0;
    if1.base_addr = '0;  if1.wr_grant = 1'b0;
    if2.pixel_in = 1'b0; if2.pixel_valid = 1'b0; if2.serpentine = 1'b0;
    if2.base_addr = '0;  if2.wr_grant = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall",      {63'b0, if1.stall},      64'h0);
    chk("rst_wr_req",     {63'b0, if1.wr_req},     64'h0);
    chk("rst_wr_addr",    {32'b0, if1.wr_addr},    64'h0);
    chk("rst_wr_data",    {32'b0, if1.wr_data},    64'h0);
    chk("rst_frame_done", {63'b0, if1.frame_done}, 64'h0);
    chk("rst_wr_req2",    {63'b0, if2.wr_req},     64'h0);
    n_rst = 1'b1;
    tick();

    // 64-bit words, 65-pixel rows: adjacent word completions at x=63,64 let a push meet a full queue.
    for (int x = 0; x < 65; x++) begin img[0][x] = (x % 2 == 0); img[1][x] = (x % 2 == 0); end
    if2.base_addr = 32'h2000;
    exp_frame(1, 64, 65, 1'b0, 32'h2000);
    for (int x = 0; x < 65; x++) send(1, img[0][x]);
    tick();
    chk("q2_full_stall", {63'b0, st2}, 64'h1);
    if2.pixel_in = img[1][0]; if2.pixel_valid = 1'b1; if2.wr_grant = 1'b1;
    tick();
    chk("q2_pop_unstalls", {63'b0, st2}, 64'h0);
    if2.pixel_valid = 1'b0; if2.wr_grant = 1'b0;
    for (int x = 1; x < 64; x++) send(1, img[1][x]);
    if2.pixel_in = img[1][64]; if2.pixel_valid = 1'b1;
    tick();
    chk("push_on_full_stall", {63'b0, st2}, 64'h1);
    if2.wr_grant = 1'b1;
    tick();
    chk("push_pop_full_same_cycle", {63'b0, st2}, 64'h0);
    if2.pixel_valid = 1'b0; if2.wr_grant = 1'b0;
    tick();
    chk("full_head_req",  {63'b0, if2.wr_req},  64'h1);
    chk("full_head_addr", {32'b0, if2.wr_addr}, 64'h2010);
    if2.wr_grant = 1'b1;
    wait_done(1, 1);

    // Raster, all ones, grant always high.
    for (int x = 0; x < 40; x++) begin img[0][x] = 1'b1; img[1][x] = 1'b1; end
    if1.base_addr = 32'h1000; if1.serpentine = 1'b0; if1.wr_grant = 1'b1;
    exp_frame(0, 32, 40, 1'b0, 32'h1000);
    send_frame1(1'b0);
    tick();
    chk("stall_after_frame", {63'b0, st1}, 64'h1);
    wait_done(0, 1);

    // Serpentine: row 1 has only its first received pixel (x=39) set.
    for (int x = 0; x < 40; x++) begin img[0][x] = 1'($urandom_range(0, 1)); img[1][x] = 1'b0; end
    img[1][39] = 1'b1;
    if1.serpentine = 1'b1;
    exp_frame(0, 32, 40, 1'b1, 32'h1000);
    send_frame1(1'b1);
    wait_done(0, 2);

    // Serpentine, random image, random grant.
    for (int x = 0; x < 40; x++) begin img[0][x] = 1'($urandom_range(0, 1)); img[1][x] = 1'($urandom_range(0, 1)); end
    if1.base_addr = 32'h3000;
    exp_frame(0, 32, 40, 1'b1, 32'h3000);
    rg1 = 1'b1;
    send_frame1(1'b1);
    wait_done(0, 3);
    rg1 = 1'b0;

    // Backpressure with no grant: two words fill the queue, the next pixel is held.
    for (int x = 0; x < 40; x++) begin img[0][x] = 1'($urandom_range(0, 1)); img[1][x] = 1'($urandom_range(0, 1)); end
    if1.base_addr = 32'h4000; if1.serpentine = 1'b0; if1.wr_grant = 1'b0;
    exp_frame(0, 32, 40, 1'b0, 32'h4000);
    for (int k = 0; k < 40; k++) send(0, img[0][k]);
    tick();
    chk("full_stall",   {63'b0, st1},          64'h1);
    chk("full_wr_req",  {63'b0, if1.wr_req},   64'h1);
    chk("full_wr_addr", {32'b0, if1.wr_addr},  64'h4000);
    if1.pixel_in = img[1][0]; if1.pixel_valid = 1'b1;
    repeat (3) tick();
    chk("held_stall", {63'b0, st1}, 64'h1);
    if1.wr_grant = 1'b1;
    for (int k = 0; k < 40; k++) send(0, img[1][k]);
    wait_done(0, 4);

    // Reset in the middle of row 1, then a fresh frame at a new base.
    for (int x = 0; x < 40; x++) begin img[0][x] = 1'($urandom_range(0, 1)); img[1][x] = 1'($urandom_range(0, 1)); end
    if1.base_addr = 32'h5000;
    exp_frame(0, 32, 40, 1'b0, 32'h5000);
    for (int k = 0; k < 40; k++) send(0, img[0][k]);
    for (int k = 0; k < 10; k++) send(0, img[1][k]);
    repeat (3) tick();
    n_rst = 1'b0;
    #1;
    chk("mid_rst_stall",      {63'b0, if1.stall},      64'h0);
    chk("mid_rst_wr_req",     {63'b0, if1.wr_req},     64'h0);
    chk("mid_rst_wr_addr",    {32'b0, if1.wr_addr},    64'h0);
    chk("mid_rst_wr_data",    {32'b0, if1.wr_data},    64'h0);
    chk("mid_rst_frame_done", {63'b0, if1.frame_done}, 64'h0);
    q1.delete();
    tick();
    n_rst = 1'b1;
    tick();
    for (int x = 0; x < 40; x++) begin img[0][x] = 1'($urandom_range(0, 1)); img[1][x] = 1'($urandom_range(0, 1)); end
    if1.base_addr = 32'h6000;
    exp_frame(0, 32, 40, 1'b0, 32'h6000);
    send_frame1(1'b0);
    wait_done(0, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
